// File: rtl/eeprom_ctrl_pkg.sv
// Shared op/state encodings and strobe payload for the EEPROM controller.
package eeprom_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ        = 2'b00,
        OP_WRITE       = 2'b01,
        OP_ERASE       = 2'b10,
        OP_ERASE_WRITE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RD_PH = 3'd2,
        ST_WR_PH = 3'd3,
        ST_ER_PH = 3'd4,
        ST_RECOV = 3'd5,
        ST_HOLD  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // EEPROM strobe bundle, registered as one unit.
    typedef struct packed {
        logic en;
        logic rd;
        logic wr;
        logic erase;
    } strobe_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_ctrl_if.sv
// Core-side request/response port of the EEPROM controller.
interface eeprom_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned WORD_SIZE = 8
) ();
    import eeprom_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    op_e                  req_op;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/eeprom_timer.sv
// Loadable phase down-counter; holds at zero, never wraps.
module eeprom_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_c
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// Sequences single-cycle core requests into timed EEPROM strobe phases.
module eeprom_ctrl
    import eeprom_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned RD_WAIT   = 2,
    parameter int unsigned WR_PULSE  = 4,
    parameter int unsigned ER_PULSE  = 8,
    parameter int unsigned RECOVERY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    eeprom_ctrl_if.slave         bus,
    output logic                 ee_en,
    output logic                 ee_rd,
    output logic                 ee_wr,
    output logic                 ee_erase,
    output logic [ADDR_SIZE-1:0] ee_a,
    output logic [WORD_SIZE-1:0] ee_d,
    input  logic [WORD_SIZE-1:0] ee_q
);

    localparam int unsigned MAX_N = max_u(max_u(RD_WAIT, WR_PULSE), max_u(ER_PULSE, RECOVERY));
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);

    state_e               state_q, state_d;
    op_e                  op_q;
    strobe_t              stb_q, stb_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic                 tmr_load;
    logic                 tmr_dec;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_zero;
    logic                 accept;
    logic                 capture;

    eeprom_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    assign accept  = bus.req_valid && ready_q && (state_q == ST_IDLE);
    assign capture = (state_q == ST_RD_PH) && tmr_zero;

    // Next-state, phase timer control, and output decode of the next state.
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = '0;
        stb_d       = '0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                tmr_load = 1'b1;
                unique case (op_q)
                    OP_READ: begin
                        state_d = ST_RD_PH;
                        tmr_val = CNT_W'(RD_WAIT - 1);
                    end
                    OP_WRITE: begin
                        state_d = ST_WR_PH;
                        tmr_val = CNT_W'(WR_PULSE - 1);
                    end
                    default: begin
                        state_d = ST_ER_PH;
                        tmr_val = CNT_W'(ER_PULSE - 1);
                    end
                endcase
            end
            ST_RD_PH: begin
                if (tmr_zero) state_d = ST_DONE;
                else          tmr_dec = 1'b1;
            end
            ST_WR_PH: begin
                if (tmr_zero) state_d = ST_HOLD;
                else          tmr_dec = 1'b1;
            end
            ST_ER_PH: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (op_q == OP_ERASE_WRITE) begin
                    state_d  = ST_RECOV;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(RECOVERY - 1);
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RECOV: begin
                if (tmr_zero) begin
                    state_d  = ST_WR_PH;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(WR_PULSE - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_SETUP, ST_RECOV, ST_HOLD: stb_d.en = 1'b1;
            ST_RD_PH: begin
                stb_d.en = 1'b1;
                stb_d.rd = 1'b1;
            end
            ST_WR_PH: begin
                stb_d.en = 1'b1;
                stb_d.wr = 1'b1;
            end
            ST_ER_PH: begin
                stb_d.en    = 1'b1;
                stb_d.erase = 1'b1;
            end
            ST_DONE: rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    // State, registered outputs, request latch and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            stb_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (capture) rdata_q <= ee_q;
        end
    end

    assign ee_en         = stb_q.en;
    assign ee_rd         = stb_q.rd;
    assign ee_wr         = stb_q.wr;
    assign ee_erase      = stb_q.erase;
    assign ee_a          = addr_q;
    assign ee_d          = wdata_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Directed self-checking bench for eeprom_ctrl with a simple EEPROM array model.
module tb_eeprom_ctrl;
    import eeprom_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       ee_en, ee_rd, ee_wr, ee_erase;
    logic [7:0] ee_a, ee_d, ee_q;
    logic       mem_load;
    logic [7:0] mem [256];

    int checks;
    int failures;

    eeprom_ctrl_if #(.ADDR_SIZE(8), .WORD_SIZE(8)) bus ();

    eeprom_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ee_en    (ee_en),
        .ee_rd    (ee_rd),
        .ee_wr    (ee_wr),
        .ee_erase (ee_erase),
        .ee_a     (ee_a),
        .ee_d     (ee_d),
        .ee_q     (ee_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EEPROM model: program writes the word, erase sets it to all ones.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[8'h10] <= 8'h5A;
        end else if (ee_en && ee_wr) begin
            mem[ee_a] <= ee_d;
        end else if (ee_en && ee_erase) begin
            mem[ee_a] <= 8'hFF;
        end
    end

    assign ee_q = (ee_en && ee_rd) ? mem[ee_a] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and trace strobes cycle by cycle until rsp_valid.
    task automatic run_op(input op_e op, input logic [7:0] addr, input logic [7:0] wdata,
                          input bit hold, output int lat, output int wait_cyc,
                          output int n_rd, output int n_wr, output int n_er, output int gap,
                          output bit bad_ovl, output bit bad_stab, output bit bad_busy);
        bit acc;
        int first_wr;
        int last_er;
        lat = -1; wait_cyc = 0; n_rd = 0; n_wr = 0; n_er = 0; gap = -1;
        bad_ovl = 1'b0; bad_stab = 1'b0; bad_busy = 1'b0;
        first_wr = -1; last_er = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        acc = 1'b0;
        for (int w = 0; w < 10 && !acc; w++) begin
            if (bus.req_ready) acc = 1'b1;
            else begin
                wait_cyc++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            bus.req_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) bus.req_valid = 1'b0;
                bus.req_addr  = ~addr;
                bus.req_wdata = ~wdata;
            end
            if (ee_rd) n_rd++;
            if (ee_wr) begin
                n_wr++;
                if (first_wr < 0) first_wr = k;
            end
            if (ee_erase) begin
                n_er++;
                last_er = k;
            end
            if ((int'(ee_rd) + int'(ee_wr) + int'(ee_erase)) > 1 ||
                ((ee_rd || ee_wr || ee_erase) && !ee_en)) bad_ovl = 1'b1;
            if (!bus.busy || bus.req_ready) bad_busy = 1'b1;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
            if (ee_a !== addr || ee_d !== wdata) bad_stab = 1'b1;
        end
        if (first_wr > 0 && last_er > 0) gap = first_wr - last_er - 1;
    endtask

    int  lat, wc, n_rd, n_wr, n_er, gap;
    bit  b_ovl, b_stab, b_busy;
    bit  saw_rsp;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        mem_load = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_WRITE;
        bus.req_addr  = 8'h55;
        bus.req_wdata = 8'hEE;

        // Reset held with a request pending: reset must win.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_strobes", 32'({ee_en, ee_rd, ee_wr, ee_erase}), 32'd0);
        chk("rst_ee_a", 32'(ee_a), 32'd0);
        chk("rst_ee_d", 32'(ee_d), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        mem_load = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_dropped", 32'(bus.busy), 32'd0);

        // READ 0x10 -> 0x5A, latency 4, RD 2 cycles.
        run_op(OP_READ, 8'h10, 8'h00, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("rd1_lat", 32'(lat), 32'd4);
        chk("rd1_rd_cycles", 32'(n_rd), 32'd2);
        chk("rd1_other", 32'(n_wr + n_er), 32'd0);
        chk("rd1_data", 32'(bus.rsp_rdata), 32'h5A);
        chk("rd1_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        chk("rd1_pulse_end", 32'(bus.rsp_valid), 32'd0);
        chk("rd1_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("rd1_idle_busy", 32'(bus.busy), 32'd0);

        // WRITE 0x3C to 0x20: WR 4 cycles, latency 7, rdata held.
        run_op(OP_WRITE, 8'h20, 8'h3C, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("wr_lat", 32'(lat), 32'd7);
        chk("wr_wr_cycles", 32'(n_wr), 32'd4);
        chk("wr_other", 32'(n_rd + n_er), 32'd0);
        chk("wr_stable", 32'(b_stab), 32'd0);
        chk("wr_overlap", 32'(b_ovl), 32'd0);
        chk("wr_rdata_held", 32'(bus.rsp_rdata), 32'h5A);

        // Read back the written word.
        run_op(OP_READ, 8'h20, 8'h00, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("rd2_data", 32'(bus.rsp_rdata), 32'h3C);

        // ERASE_WRITE 0xA5 to 0x21: ER 8, 1 gap, WR 4, latency 16.
        run_op(OP_ERASE_WRITE, 8'h21, 8'hA5, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("ew_lat", 32'(lat), 32'd16);
        chk("ew_er_cycles", 32'(n_er), 32'd8);
        chk("ew_wr_cycles", 32'(n_wr), 32'd4);
        chk("ew_gap", 32'(gap), 32'd1);
        chk("ew_overlap", 32'(b_ovl), 32'd0);
        chk("ew_stable", 32'(b_stab), 32'd0);
        chk("ew_rdata_held", 32'(bus.rsp_rdata), 32'h3C);

        // ERASE 0x10: ER 8, latency 11.
        run_op(OP_ERASE, 8'h10, 8'h00, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("er_lat", 32'(lat), 32'd11);
        chk("er_er_cycles", 32'(n_er), 32'd8);
        chk("er_wr_cycles", 32'(n_wr), 32'd0);
        chk("er_rdata_held", 32'(bus.rsp_rdata), 32'h3C);

        // Back-to-back with req_valid held across both operations.
        run_op(OP_READ, 8'h21, 8'h00, 1'b1, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("b2b1_data", 32'(bus.rsp_rdata), 32'hA5);
        chk("b2b1_busy", 32'(b_busy), 32'd0);
        run_op(OP_READ, 8'h10, 8'h00, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("b2b2_wait", 32'(wc), 32'd0);
        chk("b2b2_lat", 32'(lat), 32'd4);
        chk("b2b2_data", 32'(bus.rsp_rdata), 32'hFF);

        // Reset during the third WR_PH cycle of a WRITE.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_WRITE;
        bus.req_addr  = 8'h30;
        bus.req_wdata = 8'h77;
        chk("mid_ready", 32'(bus.req_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        chk("mid_in_wr", 32'(ee_wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_strobes", 32'({ee_en, ee_rd, ee_wr, ee_erase}), 32'd0);
        chk("mid_ready_after", 32'(bus.req_ready), 32'd1);
        chk("mid_rsp", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) saw_rsp = 1'b1;
        end
        chk("mid_no_rsp", 32'(saw_rsp), 32'd0);

        // Controller still functional after the aborted write.
        run_op(OP_READ, 8'h20, 8'h00, 1'b0, lat, wc, n_rd, n_wr, n_er, gap, b_ovl, b_stab, b_busy);
        chk("post_lat", 32'(lat), 32'd4);
        chk("post_data", 32'(bus.rsp_rdata), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
